// File: rtl/vec_widen_seq.sv
// ---------------------------------------------------------------------------
// vec_widen_seq
//
// Sequencer for the element widening datapath in the vector unit. Takes
// packed words of W_IN-bit elements, widens each element to W_OUT = 2*W_IN
// bits and emits each word as two half-group beats over a valid/ready stream.
// It stops after vl elements and zeroes any lane whose element index is at
// or beyond vl.
//
// Configuration macro: VEC_WIDEN_ZEXT_EN
//   defined   : sign_i is latched on start; 0 selects zero-extension.
//   undefined : sign_i is ignored and every element is sign-extended.
//
// Ports:
//   clk          in   rising-edge clock
//   n_reset      in   asynchronous active-low reset
//   start_i      in   begin an operation (sampled only in IDLE)
//   vl_i         in   element count, latched on an accepted start
//   sign_i       in   1 = sign-extend, 0 = zero-extend (see macro)
//   in_valid_i   in   input word valid
//   in_ready_o   out  input word accepted this cycle when valid
//   in_data_i    in   packed elements, element 0 in the LSBs
//   out_valid_o  out  output beat valid
//   out_ready_i  in   consumer accepts the beat
//   out_data_o   out  widened half-group, lowest element in the LSBs
//   out_last_o   out  current beat is the final beat of the operation
//   busy_o       out  any state other than IDLE
//   done_o       out  one-cycle completion pulse
// ---------------------------------------------------------------------------
module vec_widen_seq #(
    parameter int W_IN     = 8,
    parameter int W_OUT    = 16,
    parameter int IN_ELEMS = 4,
    parameter int VL_W     = 8
) (
    input  logic                              clk,
    input  logic                              n_reset,
    input  logic                              start_i,
    input  logic [VL_W-1:0]                   vl_i,
    input  logic                              sign_i,
    input  logic                              in_valid_i,
    output logic                              in_ready_o,
    input  logic [IN_ELEMS*W_IN-1:0]          in_data_i,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic [(IN_ELEMS/2)*W_OUT-1:0]     out_data_o,
    output logic                              out_last_o,
    output logic                              busy_o,
    output logic                              done_o
);

    localparam int HALF = IN_ELEMS / 2;
    localparam logic [VL_W-1:0] HALF_VL = VL_W'(HALF);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EMIT_LO,
        S_EMIT_HI,
        S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [VL_W-1:0]          rem_q, rem_d;   // elements not yet emitted
    logic [IN_ELEMS*W_IN-1:0] word_q;
    logic                     ext_sign;

`ifdef VEC_WIDEN_ZEXT_EN
    logic sign_q;
    assign ext_sign = sign_q;
`else
    logic unused_sign;
    assign unused_sign = sign_i;
    assign ext_sign    = 1'b1;
`endif

    logic emitting;
    logic final_half;

    assign emitting   = (state_q == S_EMIT_LO) || (state_q == S_EMIT_HI);
    // rem counts from the first lane of the current half, so the beat that
    // covers the remaining elements is the last one.
    assign final_half = (rem_q <= HALF_VL);

    // Next-state logic.
    // NOTE: every signal written here gets a default first so no path
    // through the case leaves it unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    rem_d   = vl_i;
                    state_d = (vl_i == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (in_valid_i) state_d = S_EMIT_LO;
            end
            S_EMIT_LO: begin
                if (out_ready_i) begin
                    rem_d   = final_half ? '0 : rem_q - HALF_VL;
                    state_d = final_half ? S_DONE : S_EMIT_HI;
                end
            end
            S_EMIT_HI: begin
                if (out_ready_i) begin
                    rem_d   = final_half ? '0 : rem_q - HALF_VL;
                    state_d = final_half ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            // NOTE: the word register is reset even though it is only read in
            // the emit states; out_data_o is gated anyway, but a defined value
            // keeps simulation free of X on the held word after reset.
            word_q  <= '0;
`ifdef VEC_WIDEN_ZEXT_EN
            sign_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            if (state_q == S_FETCH && in_valid_i) begin
                word_q <= in_data_i;
            end
`ifdef VEC_WIDEN_ZEXT_EN
            if (state_q == S_IDLE && start_i) begin
                sign_q <= sign_i;
            end
`endif
        end
    end

    // Output decode: all from registered state, no path from the handshake
    // inputs to any output.
    assign in_ready_o  = (state_q == S_FETCH);
    assign out_valid_o = emitting;
    assign out_last_o  = emitting && final_half;
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);

    logic [HALF*W_IN-1:0] half_word;
    logic [W_IN-1:0]      elem;

    always_comb begin
        out_data_o = '0;
        elem       = '0;
        half_word  = (state_q == S_EMIT_HI) ? word_q[IN_ELEMS*W_IN-1 -: HALF*W_IN]
                                            : word_q[HALF*W_IN-1:0];
        if (emitting) begin
            for (int j = 0; j < HALF; j++) begin
                elem = half_word[j*W_IN +: W_IN];
                // Lane j of this half is live only while j < remaining count;
                // trailing lanes past vl stay zero.
                if (VL_W'(j) < rem_q) begin
                    out_data_o[j*W_OUT +: W_OUT] =
                        {{W_IN{ext_sign & elem[W_IN-1]}}, elem};
                end
            end
        end
    end

endmodule

// File: tb/tb_vec_widen_seq.sv
// ---------------------------------------------------------------------------
// tb_vec_widen_seq
//
// Self-checking bench for vec_widen_seq with the default parameters
// (W_IN=8, W_OUT=16, IN_ELEMS=4, VL_W=8). Expected beats are computed from
// the stimulus and queued when an operation starts; a consumer process pops
// and compares them as the DUT hands beats over, optionally stalling each
// beat for three cycles.
// ---------------------------------------------------------------------------
module tb_vec_widen_seq;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        start_i = 1'b0;
    logic [7:0]  vl_i = '0;
    logic        sign_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] in_data_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] out_data_o;
    logic        out_last_o;
    logic        busy_o;
    logic        done_o;

    vec_widen_seq #(
        .W_IN(8), .W_OUT(16), .IN_ELEMS(4), .VL_W(8)
    ) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .start_i     (start_i),
        .vl_i        (vl_i),
        .sign_i      (sign_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_last_o  (out_last_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    bit          stall_mode   = 1'b0;
    bit          manual_ready = 1'b0;
    int          hold_cnt     = 0;
    logic [31:0] held_data    = '0;
    logic        held_last    = 1'b0;
    int          beats_seen   = 0;
    int          ready_seen   = 0;
    int          done_cnt     = 0;
    int          last_hs_cyc  = 0;
    logic        prev_done    = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: queue the beats one operation should produce.
    function automatic int push_expected(input logic [7:0] vl, input logic sign,
                                         input int nwords, input logic [31:0] w0,
                                         input logic [31:0] w1);
        int          n;
        logic        s;
        logic [31:0] w;
        logic [7:0]  e;
        int          base;
        int          idx;
        beat_t       b;
        n = 0;
`ifdef VEC_WIDEN_ZEXT_EN
        s = sign;
`else
        s = 1'b1;
`endif
        for (int k = 0; k < nwords; k++) begin
            w = (k == 0) ? w0 : w1;
            for (int h = 0; h < 2; h++) begin
                base = k * 4 + h * 2;
                if (base < int'(vl)) begin
                    b.data = '0;
                    for (int j = 0; j < 2; j++) begin
                        idx = base + j;
                        e   = w[(h*2+j)*8 +: 8];
                        if (idx < int'(vl))
                            b.data[j*16 +: 16] = s ? {{8{e[7]}}, e} : {8'h00, e};
                    end
                    b.last = (base + 2 >= int'(vl));
                    exp_q.push_back(b);
                    n++;
                end
            end
        end
        return n;
    endfunction

    // Consumer / monitor: decides out_ready_i on the falling edge, so a beat
    // seen here with ready driven high is taken on the next rising edge.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (!n_reset) begin
                hold_cnt  = 0;
                prev_done = 1'b0;
                continue;
            end
            if (in_ready_o) ready_seen++;
            if (done_o) begin
                done_cnt++;
                check("done_single_pulse", prev_done, 1'b0);
            end
            prev_done = done_o;
            if (manual_ready) continue;
            if (out_valid_o) begin
                if (stall_mode && hold_cnt < 3) begin
                    if (hold_cnt == 0) begin
                        held_data = out_data_o;
                        held_last = out_last_o;
                    end else begin
                        check("stall_data_hold", out_data_o, held_data);
                        check("stall_last_hold", out_last_o, held_last);
                    end
                    out_ready_i = 1'b0;
                    hold_cnt++;
                end else begin
                    if (hold_cnt > 0) begin
                        check("stall_data_hold", out_data_o, held_data);
                        check("stall_last_hold", out_last_o, held_last);
                    end
                    out_ready_i = 1'b1;
                    hold_cnt    = 0;
                    beats_seen++;
                    if (exp_q.size() == 0) begin
                        check("beat_unexpected", out_valid_o, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", out_data_o, e.data);
                        check("beat_last", out_last_o, e.last);
                        if (out_last_o) last_hs_cyc = cyc;
                    end
                end
            end else begin
                out_ready_i = !stall_mode;
            end
        end
    end

    task automatic run_op(input logic [7:0] vl, input logic sign, input int nwords,
                          input logic [31:0] w0, input logic [31:0] w1, input bit stall);
        int nbeats;
        int b0;
        int r0;
        bit seen;
        nbeats     = push_expected(vl, sign, nwords, w0, w1);
        stall_mode = stall;
        b0         = beats_seen;
        r0         = ready_seen;

        @(posedge clk); #1;
        start_i = 1'b1;
        vl_i    = vl;
        sign_i  = sign;
        @(posedge clk); #1;
        start_i = 1'b0;
        vl_i    = 8'($urandom);  // latched values must not follow these
        sign_i  = ~sign;
        check("busy_after_start", busy_o, 1'b1);
        if (vl == 0) begin
            check("zero_vl_done", done_o, 1'b1);
            check("zero_vl_ready", in_ready_o, 1'b0);
        end else begin
            check("ready_after_start", in_ready_o, 1'b1);
        end

        for (int k = 0; k < nwords; k++) begin
            in_valid_i = 1'b1;
            in_data_i  = (k == 0) ? w0 : w1;
            seen = 1'b0;
            for (int t = 0; t < 100 && !seen; t++) begin
                @(negedge clk);
                seen = in_ready_o;
            end
            check("word_accept_timeout", seen, 1'b1);
            @(posedge clk); #1;
            in_valid_i = 1'b0;
            in_data_i  = $urandom;
            check("valid_after_word", out_valid_o, 1'b1);
        end

        if (vl != 0) begin
            seen = 1'b0;
            for (int t = 0; t < 300 && !seen; t++) begin
                @(negedge clk);
                seen = done_o;
            end
            check("done_timeout", seen, 1'b1);
            check("done_latency", cyc, last_hs_cyc + 1);
        end else begin
            @(negedge clk);
        end
        @(negedge clk);
        check("done_pulse_width", done_o, 1'b0);
        check("busy_cleared", busy_o, 1'b0);
        check("queue_drained", exp_q.size(), 0);
        check("beat_count", beats_seen - b0, nbeats);
        if (vl == 0) check("zero_vl_no_ready", ready_seen - r0, 0);
    endtask

    initial begin
        int          done0;
        logic [7:0]  rvl;
        logic [31:0] rw0;
        logic [31:0] rw1;

        // Reset state.
        #12;
        check("rst_in_ready", in_ready_o, 1'b0);
        check("rst_out_valid", out_valid_o, 1'b0);
        check("rst_out_data", out_data_o, 32'h0);
        check("rst_out_last", out_last_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        @(negedge clk);
        n_reset = 1'b1;

        run_op(8'd4, 1'b1, 1, 32'h807FFF01, 32'h0, 1'b0);
        run_op(8'd3, 1'b1, 1, 32'h807FFF01, 32'h0, 1'b0);
        run_op(8'd1, 1'b1, 1, 32'h807FFF01, 32'h0, 1'b0);
        run_op(8'd0, 1'b1, 0, 32'h0, 32'h0, 1'b0);
        run_op(8'd8, 1'b1, 2, 32'h03020100, 32'h87868584, 1'b1);
        run_op(8'd2, 1'b0, 1, 32'h000080FF, 32'h0, 1'b0);
        run_op(8'd2, 1'b1, 1, 32'h000080FF, 32'h0, 1'b0);

        for (int r = 0; r < 4; r++) begin
            rvl = 8'($urandom_range(1, 8));
            rw0 = $urandom;
            rw1 = $urandom;
            run_op(rvl, 1'($urandom_range(0, 1)), (int'(rvl) + 3) / 4, rw0, rw1, r[0]);
        end

        // Reset in the middle of EMIT_HI with a beat pending.
        manual_ready = 1'b1;
        out_ready_i  = 1'b0;
        @(posedge clk); #1;
        start_i = 1'b1;
        vl_i    = 8'd4;
        sign_i  = 1'b1;
        @(posedge clk); #1;
        start_i    = 1'b0;
        in_valid_i = 1'b1;
        in_data_i  = 32'h807FFF01;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        check("mid_lo_valid", out_valid_o, 1'b1);
        out_ready_i = 1'b1;
        @(posedge clk); #1;
        out_ready_i = 1'b0;
        check("mid_hi_valid", out_valid_o, 1'b1);
        check("mid_hi_data", out_data_o, 32'hFF80007F);
        done0 = done_cnt;
        #2;
        n_reset = 1'b0;
        #1;
        check("async_rst_valid", out_valid_o, 1'b0);
        check("async_rst_data", out_data_o, 32'h0);
        check("async_rst_last", out_last_o, 1'b0);
        check("async_rst_busy", busy_o, 1'b0);
        check("async_rst_done", done_o, 1'b0);
        check("async_rst_ready", in_ready_o, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_reset      = 1'b1;
        manual_ready = 1'b0;
        @(negedge clk);
        check("rst_no_done", done_cnt - done0, 0);
        check("rst_idle_busy", busy_o, 1'b0);

        run_op(8'd2, 1'b1, 1, 32'h12345678, 32'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
